// File: rtl/axi_pkg.sv
// Shared AXI write-channel constants, FSM encoding and AW queue entry layout.
// The queue entry's ID and address fields are parameter-sized, so they are packed in the top.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] region;
    logic [1:0] err;
  } aw_ctl_t;

  localparam int AW_CTL_W = $bits(aw_ctl_t);

  // Decode errors outrank slave errors so a bad region is always reported as DECERR.
  function automatic logic [1:0] decode_err(input logic [3:0] region,
                                            input logic [7:0] len,
                                            input logic [2:0] size,
                                            input logic [1:0] burst,
                                            input int         num_tgt,
                                            input int         max_size);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    if (int'(region) >= num_tgt)
      return RESP_DECERR;
    else if (burst == 2'b11 || int'(size) > max_size || bad_wrap)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/axi_write_slave_mt.sv
// AXI4 write-channel slave: queued AW bursts, FIXED/INCR/WRAP address generation,
// error responses and a ready/valid internal write port with a decoded target index.
module axi_write_slave_mt
  import axi_pkg::*;
#(
  parameter int ID_W     = 8,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int NUM_TGT  = 3,
  parameter int AW_DEPTH = 4,
  parameter int TGT_W    = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic [3:0]        AWREGION,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              wr_vld,
  input  logic              wr_rdy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [STRB_W-1:0] wr_strb,
  output logic [TGT_W-1:0]  wr_tgt,
  output logic [1:0]        state_dbg
);

  localparam int MAX_SIZE = $clog2(STRB_W);
  localparam int ENT_W    = ID_W + ADDR_W + AW_CTL_W;
  localparam int CNT_W    = $clog2(AW_DEPTH) + 1;

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; valid never waits on ready, and payload is held while valid.

  state_e            state;
  logic              aw_push;
  logic              aw_pop;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  q_count_next;
  logic [ENT_W-1:0]  q_wdata;
  logic [ENT_W-1:0]  q_rdata;
  aw_ctl_t           push_ctl;
  aw_ctl_t           head_ctl;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W-1:0] head_addr;

  logic [ID_W-1:0]   b_id;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_len;
  logic [7:0]        b_cnt;
  logic [2:0]        b_size;
  logic [1:0]        b_burst;
  logic [3:0]        b_region;
  logic [1:0]        b_err;
  logic              wlast_err;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;
  logic              w_accept;

  always_comb begin
    push_ctl        = '0;
    push_ctl.len    = AWLEN;
    push_ctl.size   = AWSIZE;
    push_ctl.burst  = AWBURST;
    push_ctl.region = AWREGION;
    push_ctl.err    = decode_err(AWREGION, AWLEN, AWSIZE, AWBURST, NUM_TGT, MAX_SIZE);
  end

  assign q_wdata                       = {AWID, AWADDR, push_ctl};
  assign {head_id, head_addr, head_ctl} = q_rdata;
  assign aw_push                       = AWVALID && AWREADY && !q_full;
  assign aw_pop                        = (state == ST_IDLE) && !q_empty;
  assign q_count_next                  = q_count + CNT_W'(aw_push) - CNT_W'(aw_pop);

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (AW_DEPTH),
    .CNT_W (CNT_W)
  ) u_aw_q (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .wdata (q_wdata),
    .pop   (aw_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // WRAP keeps the beat inside an aligned window of (len+1) beats.
  always_comb begin
    step      = ADDR_W'(1) << b_size;
    addr_inc  = b_addr + step;
    wrap_mask = ((ADDR_W'(b_len) + ADDR_W'(1)) << b_size) - ADDR_W'(1);
    case (b_burst)
      BURST_FIXED: next_addr = b_addr;
      BURST_WRAP:  next_addr = (b_addr & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     next_addr = addr_inc;
    endcase
  end

  assign WREADY    = (state == ST_BURST) && (!wr_vld || wr_rdy);
  assign w_accept  = WVALID && WREADY;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      AWREADY   <= 1'b0;
      BVALID    <= 1'b0;
      BID       <= '0;
      BRESP     <= RESP_OKAY;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      wr_tgt    <= '0;
      b_id      <= '0;
      b_addr    <= '0;
      b_len     <= '0;
      b_cnt     <= '0;
      b_size    <= '0;
      b_burst   <= '0;
      b_region  <= '0;
      b_err     <= RESP_OKAY;
      wlast_err <= 1'b0;
    end else begin
      AWREADY <= (q_count_next != CNT_W'(AW_DEPTH));
      if (wr_vld && wr_rdy)
        wr_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            b_id      <= head_id;
            b_addr    <= head_addr;
            b_len     <= head_ctl.len;
            b_cnt     <= head_ctl.len;
            b_size    <= head_ctl.size;
            b_burst   <= head_ctl.burst;
            b_region  <= head_ctl.region;
            b_err     <= head_ctl.err;
            wlast_err <= 1'b0;
            state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            // Errored bursts still drain their beats, but nothing reaches the targets.
            if (b_err == RESP_OKAY) begin
              wr_vld  <= 1'b1;
              wr_addr <= b_addr;
              wr_data <= WDATA;
              wr_strb <= WSTRB;
              wr_tgt  <= TGT_W'(b_region);
            end
            if (WLAST != (b_cnt == 8'd0))
              wlast_err <= 1'b1;
            b_cnt  <= b_cnt - 8'd1;
            b_addr <= next_addr;
            if (b_cnt == 8'd0)
              state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!BVALID) begin
            if (!wr_vld) begin
              BVALID <= 1'b1;
              BID    <= b_id;
              if (b_err != RESP_OKAY)
                BRESP <= b_err;
              else if (wlast_err)
                BRESP <= RESP_SLVERR;
              else
                BRESP <= RESP_OKAY;
            end
          end else if (BREADY) begin
            BVALID <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_slave_mt.sv
// Directed bench for axi_write_slave_mt: burst addressing, AW queueing, error
// responses, WLAST mismatch, target back-pressure and reset.
module tb_axi_write_slave_mt;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID;
  logic [10:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWREGION;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        wr_vld;
  logic        wr_rdy = 1'b1;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_tgt;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int vld_seen = 0;

  logic [10:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [1:0]  cap_tgt[$];
  int          cap_cyc[$];
  logic [10:0] exp_q[$];

  axi_write_slave_mt dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_tgt(wr_tgt), .state_dbg(state_dbg)
  );

  // Clock / cycle counter / target ready pattern
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (rdy_mode)
      0:       wr_rdy = 1'b1;
      1:       wr_rdy = ~wr_rdy;
      default: wr_rdy = 1'b0;
    endcase
  end

  // Internal write-port monitor: records every beat the target accepts
  always @(negedge clk) begin
    if (wr_vld) begin
      vld_seen = vld_seen + 1;
      if (wr_rdy) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        cap_tgt.push_back(wr_tgt);
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
    cap_tgt.delete();
    cap_cyc.delete();
    exp_q.delete();
    vld_seen = 0;
  endtask

  // Driver tasks: called and return on a falling edge
  task automatic send_aw(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region);
    bit done;
    done = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWREGION = region;
    AWVALID = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (AWREADY) done = 1'b1;
      @(negedge clk);
    end
    AWVALID = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL aw_handshake id=%h: got no AWREADY, expected AWREADY within 40 cycles", id);
    end
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit done;
    done = 1'b0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (WREADY) done = 1'b1;
      @(negedge clk);
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL w_handshake data=%h: got no WREADY, expected WREADY within 60 cycles", data);
    end
  endtask

  task automatic get_b(output logic [7:0] id, output logic [1:0] resp);
    bit done;
    done = 1'b0;
    id = 8'hxx;
    resp = 2'bxx;
    BREADY = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (BVALID) begin
        done = 1'b1;
        id = BID;
        resp = BRESP;
      end
      @(negedge clk);
    end
    BREADY = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b_handshake: got no BVALID, expected BVALID within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWREGION = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (AWREADY !== 1'b0) begin
      errors++; $display("FAIL reset_awready: got %b expected 0", AWREADY);
    end
    checks++;
    if ({WREADY, BVALID, BID, BRESP, wr_vld, wr_addr, wr_data, wr_strb, wr_tgt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wready=%b bvalid=%b bid=%h bresp=%b vld=%b addr=%h data=%h strb=%h tgt=%h expected all 0",
               WREADY, BVALID, BID, BRESP, wr_vld, wr_addr, wr_data, wr_strb, wr_tgt);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL reset_release_awready: got %b expected 1", AWREADY);
    end
  endtask

  task automatic test_incr();
    logic [7:0] id;
    logic [1:0] resp;
    clear_caps();
    exp_q = '{11'h010, 11'h014, 11'h018, 11'h01C};
    send_aw(8'h5A, 11'h010, 8'd3, 3'd2, BURST_INCR, 4'd1);
    for (int i = 0; i < 4; i++) send_w(32'hA000_0000 + 32'(i), 4'hF, i == 3);
    get_b(id, resp);
    checks++;
    if (cap_addr.size() != 4) begin
      errors++; $display("FAIL incr_beats: got %0d expected 4", cap_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_addr[i] !== exp_q[i] || cap_data[i] !== 32'hA000_0000 + 32'(i) || cap_tgt[i] !== 2'd1) begin
          errors++;
          $display("FAIL incr_beat%0d: got addr=%h data=%h tgt=%0d expected addr=%h data=%h tgt=1",
                   i, cap_addr[i], cap_data[i], cap_tgt[i], exp_q[i], 32'hA000_0000 + 32'(i));
        end
      end
      checks++;
      if (cap_cyc[3] - cap_cyc[0] != 3) begin
        errors++; $display("FAIL incr_throughput: got span %0d cycles expected 3", cap_cyc[3] - cap_cyc[0]);
      end
    end
    checks++;
    if (id !== 8'h5A || resp !== RESP_OKAY) begin
      errors++; $display("FAIL incr_bresp: got bid=%h bresp=%b expected bid=5a bresp=00", id, resp);
    end
  endtask

  task automatic test_wrap_fixed();
    logic [7:0] id;
    logic [1:0] resp;
    clear_caps();
    exp_q = '{11'h038, 11'h03C, 11'h030, 11'h034, 11'h020, 11'h020, 11'h020};
    send_aw(8'h11, 11'h038, 8'd3, 3'd2, BURST_WRAP, 4'd0);
    for (int i = 0; i < 4; i++) send_w(32'hB000_0000 + 32'(i), 4'hF, i == 3);
    get_b(id, resp);
    send_aw(8'h12, 11'h020, 8'd2, 3'd2, BURST_FIXED, 4'd2);
    for (int i = 0; i < 3; i++) send_w(32'hB100_0000 + 32'(i), 4'h3, i == 2);
    get_b(id, resp);
    checks++;
    if (cap_addr.size() != 7) begin
      errors++; $display("FAIL wrap_fixed_beats: got %0d expected 7", cap_addr.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (cap_addr[i] !== exp_q[i]) begin
          errors++; $display("FAIL wrap_fixed_addr%0d: got %h expected %h", i, cap_addr[i], exp_q[i]);
        end
      end
      checks++;
      if (cap_tgt[6] !== 2'd2) begin
        errors++; $display("FAIL fixed_tgt: got %0d expected 2", cap_tgt[6]);
      end
    end
    checks++;
    if (id !== 8'h12 || resp !== RESP_OKAY) begin
      errors++; $display("FAIL fixed_bresp: got bid=%h bresp=%b expected bid=12 bresp=00", id, resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] id;
    logic [1:0] resp;
    int accepted;
    bit got;
    clear_caps();
    accepted = 0;
    // One burst leaves the queue immediately, so four more fill it before AWREADY drops.
    for (int i = 0; i < 6; i++) begin
      AWID = 8'(i + 1); AWADDR = 11'h100 + 11'(16 * i); AWLEN = 0; AWSIZE = 3'd2;
      AWBURST = BURST_INCR; AWREGION = 4'd0; AWVALID = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        if (AWREADY) got = 1'b1;
        @(negedge clk);
      end
      if (got) accepted++;
    end
    AWVALID = 1'b0;
    checks++;
    if (accepted != 5) begin
      errors++; $display("FAIL queue_accepts: got %0d expected 5", accepted);
    end
    checks++;
    if (AWREADY !== 1'b0) begin
      errors++; $display("FAIL queue_full_awready: got %b expected 0", AWREADY);
    end
    send_w(32'hC000_0001, 4'hF, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (BVALID !== 1'b1 || BID !== 8'h01) begin
      errors++; $display("FAIL bready_low_hold: got bvalid=%b bid=%h expected bvalid=1 bid=01", BVALID, BID);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) send_w(32'hC000_0001 + 32'(i), 4'hF, 1'b1);
      get_b(id, resp);
      checks++;
      if (id !== 8'(i + 1) || resp !== RESP_OKAY) begin
        errors++; $display("FAIL b_order%0d: got bid=%h bresp=%b expected bid=%h bresp=00", i, id, resp, 8'(i + 1));
      end
    end
    checks++;
    if (cap_addr.size() != 5 || cap_addr[4] !== 11'h140) begin
      errors++; $display("FAIL queue_beats: got %0d beats last=%h expected 5 beats last=140",
                         cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[cap_addr.size()-1] : 11'h0);
    end
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL queue_drained_awready: got %b expected 1", AWREADY);
    end
  endtask

  task automatic test_errors();
    logic [7:0] id;
    logic [1:0] resp;
    clear_caps();
    send_aw(8'h21, 11'h300, 8'd1, 3'd2, BURST_INCR, 4'd5);
    send_w(32'hD000_0000, 4'hF, 1'b0);
    send_w(32'hD000_0001, 4'hF, 1'b1);
    get_b(id, resp);
    checks++;
    if (id !== 8'h21 || resp !== RESP_DECERR) begin
      errors++; $display("FAIL decerr_bresp: got bid=%h bresp=%b expected bid=21 bresp=11", id, resp);
    end
    send_aw(8'h22, 11'h300, 8'd0, 3'd2, 2'b11, 4'd0);
    send_w(32'hD000_0002, 4'hF, 1'b1);
    get_b(id, resp);
    checks++;
    if (id !== 8'h22 || resp !== RESP_SLVERR) begin
      errors++; $display("FAIL bad_burst_bresp: got bid=%h bresp=%b expected bid=22 bresp=10", id, resp);
    end
    send_aw(8'h23, 11'h300, 8'd0, 3'd3, BURST_INCR, 4'd0);
    send_w(32'hD000_0003, 4'hF, 1'b1);
    get_b(id, resp);
    checks++;
    if (resp !== RESP_SLVERR) begin
      errors++; $display("FAIL bad_size_bresp: got %b expected 10", resp);
    end
    send_aw(8'h24, 11'h300, 8'd2, 3'd2, BURST_WRAP, 4'd0);
    for (int i = 0; i < 3; i++) send_w(32'hD000_0010 + 32'(i), 4'hF, i == 2);
    get_b(id, resp);
    checks++;
    if (resp !== RESP_SLVERR) begin
      errors++; $display("FAIL bad_wrap_len_bresp: got %b expected 10", resp);
    end
    checks++;
    if (vld_seen != 0) begin
      errors++; $display("FAIL err_suppress: got wr_vld high %0d cycles expected 0", vld_seen);
    end
  endtask

  task automatic test_wlast_and_stall();
    logic [7:0] id;
    logic [1:0] resp;
    clear_caps();
    send_aw(8'h31, 11'h040, 8'd3, 3'd2, BURST_INCR, 4'd1);
    for (int i = 0; i < 4; i++) send_w(32'hE000_0000 + 32'(i), 4'hF, i == 1);
    get_b(id, resp);
    checks++;
    if (cap_addr.size() != 4 || resp !== RESP_SLVERR) begin
      errors++; $display("FAIL wlast_mismatch: got beats=%0d bresp=%b expected beats=4 bresp=10", cap_addr.size(), resp);
    end
    checks++;
    if (WREADY !== 1'b0) begin
      errors++; $display("FAIL wready_idle: got %b expected 0", WREADY);
    end
    clear_caps();
    rdy_mode = 1;
    exp_q = '{11'h080, 11'h084, 11'h088, 11'h08C};
    send_aw(8'h32, 11'h080, 8'd3, 3'd2, BURST_INCR, 4'd2);
    for (int i = 0; i < 4; i++) send_w(32'hF000_0000 + 32'(i), 4'hF, i == 3);
    get_b(id, resp);
    rdy_mode = 0;
    checks++;
    if (cap_addr.size() != 4) begin
      errors++; $display("FAIL stall_beats: got %0d expected 4", cap_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_addr[i] !== exp_q[i] || cap_data[i] !== 32'hF000_0000 + 32'(i)) begin
          errors++; $display("FAIL stall_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                             i, cap_addr[i], cap_data[i], exp_q[i], 32'hF000_0000 + 32'(i));
        end
      end
    end
    checks++;
    if (id !== 8'h32 || resp !== RESP_OKAY) begin
      errors++; $display("FAIL stall_bresp: got bid=%h bresp=%b expected bid=32 bresp=00", id, resp);
    end
  endtask

  task automatic test_top_and_reset();
    logic [7:0] id;
    logic [1:0] resp;
    clear_caps();
    send_aw(8'h41, 11'h7FC, 8'd1, 3'd2, BURST_INCR, 4'd0);
    send_w(32'h1111_1111, 4'hF, 1'b0);
    send_w(32'h2222_2222, 4'hF, 1'b1);
    get_b(id, resp);
    checks++;
    if (cap_addr.size() != 2 || cap_addr[0] !== 11'h7FC || cap_addr[1] !== 11'h000) begin
      errors++; $display("FAIL addr_wrap_top: got %0d beats first=%h expected 2 beats 7fc,000",
                         cap_addr.size(), (cap_addr.size() > 0) ? cap_addr[0] : 11'h0);
    end
    rdy_mode = 2;
    send_aw(8'h51, 11'h200, 8'd3, 3'd2, BURST_INCR, 4'd1);
    send_aw(8'h52, 11'h210, 8'd0, 3'd2, BURST_INCR, 4'd1);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b0);
    checks++;
    if (wr_vld !== 1'b1 || wr_addr !== 11'h200) begin
      errors++; $display("FAIL pre_reset_beat: got vld=%b addr=%h expected vld=1 addr=200", wr_vld, wr_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, BVALID, BID, BRESP, wr_vld, wr_addr, wr_data, wr_strb, wr_tgt, state_dbg} !== '0) begin
      errors++;
      $display("FAIL midburst_reset: got awready=%b wready=%b bvalid=%b vld=%b addr=%h data=%h state=%0d expected all 0",
               AWREADY, WREADY, BVALID, wr_vld, wr_addr, wr_data, state_dbg);
    end
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    checks++;
    if (AWREADY !== 1'b1) begin
      errors++; $display("FAIL post_reset_awready: got %b expected 1", AWREADY);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0 || wr_vld !== 1'b0) begin
      errors++; $display("FAIL queue_flushed: got state=%0d vld=%b expected state=0 vld=0", state_dbg, wr_vld);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_back_to_back();
    test_errors();
    test_wlast_and_stall();
    test_top_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
